// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end.
// Holds the PC and reads the combinational instruction memory.
// Fetched words are queued with their PCs in a small FIFO that feeds decode.
// Branch redirects flush the queue and restart fetch at the new PC.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter int          ADDR_W    = 8,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_oob,
    output logic              misalign_err,
    output logic [31:0]       instr_count
);

    localparam int              PTR_W    = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(BUF_DEPTH);
    localparam logic [31:0]     PC_LIMIT = 32'(MEM_WORDS * 4);

    logic [31:0]      pc_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [31:0]      instr_count_reg;
    logic             misalign_reg;
    logic [31:0]      buf_instr_reg [BUF_DEPTH];
    logic [31:0]      buf_pc_reg    [BUF_DEPTH];

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty    = (count_reg != '0);
    assign fetch_oob    = (pc_reg >= PC_LIMIT);
    assign imem_addr    = pc_reg[ADDR_W+1:2];
    assign if_valid     = not_empty && !redirect_valid;
    assign if_instr     = not_empty ? buf_instr_reg[head_reg] : 32'h0;
    assign if_pc        = not_empty ? buf_pc_reg[head_reg]    : 32'h0;
    assign misalign_err = misalign_reg;
    assign instr_count  = instr_count_reg;

    // Fullness uses the registered count, so a pop never frees a slot in the same cycle.
    assign push = (count_reg != FULL_CNT) && !fetch_oob && !redirect_valid;
    assign pop  = if_valid && id_ready;

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // PC, queue pointers, transfer counter and sticky misalignment flag; redirect wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            count_reg       <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            instr_count_reg <= 32'h0;
            misalign_reg    <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg    <= {redirect_pc[31:2], 2'b00};
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else begin
            count_reg <= count_next;
            if (push) begin
                pc_reg   <= pc_reg + 32'd4;
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg        <= head_reg + 1'b1;
                instr_count_reg <= instr_count_reg + 32'd1;
            end
        end
    end

    // Queue storage: the fetched word and its PC land at the tail slot on a push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_reg[i] <= 32'h0;
                buf_pc_reg[i]    <= 32'h0;
            end
        end else if (push) begin
            buf_instr_reg[tail_reg] <= imem_data;
            buf_pc_reg[tail_reg]    <= pc_reg;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, backpressure, redirects,
// misaligned targets, out-of-range fetch and asynchronous mid-run reset.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_oob;
    logic        misalign_err;
    logic [31:0] instr_count;

    logic [31:0] imem [256];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] W63 = 32'h1000_003F;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(64),
        .ADDR_W   (8),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_oob     (fetch_oob),
        .misalign_err  (misalign_err),
        .instr_count   (instr_count)
    );

    assign imem_data = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Check the head of the fetch queue as seen by decode.
    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, instr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 + i;
        imem[0] = 32'h00002083; imem[1] = 32'h00402103; imem[2] = 32'h000001b3;
        imem[3] = 32'h00000233; imem[4] = 32'h001181b3; imem[5] = 32'h00320233;
        imem[6] = 32'h00218463; imem[7] = 32'hfe000ae3; imem[8] = 32'h00401623;

        rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state
        tick(); tick(); #1;
        check("rst.valid", {31'b0, if_valid}, 32'd0);
        check("rst.pc", if_pc, 32'h0);
        check("rst.instr", if_instr, 32'h0);
        check("rst.count", instr_count, 32'd0);
        check("rst.addr", {24'b0, imem_addr}, 32'd0);
        check("rst.mis", {31'b0, misalign_err}, 32'd0);
        check("rst.oob", {31'b0, fetch_oob}, 32'd0);

        // Streaming with id_ready high: one instruction per cycle
        tick(); rst = 1'b1; #1;
        check("lat.valid0", {31'b0, if_valid}, 32'd0);
        tick(); #1; check_head("s0", 32'h0, 32'h00002083); check("s0.cnt", instr_count, 32'd0);
        tick(); #1; check_head("s1", 32'h4, 32'h00402103); check("s1.cnt", instr_count, 32'd1);
        tick(); #1; check_head("s2", 32'h8, 32'h000001b3); check("s2.cnt", instr_count, 32'd2);
        tick(); #1; check("s3.cnt", instr_count, 32'd3);

        // Redirect to 0x10 while streaming
        redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        check("rd.validN", {31'b0, if_valid}, 32'd0);
        tick(); redirect_valid = 1'b0; #1;
        check("rd.validN1", {31'b0, if_valid}, 32'd0);
        check("rd.cnt", instr_count, 32'd3);
        tick(); #1; check_head("rd.N2", 32'h10, 32'h001181b3);
        tick(); #1; check_head("rd.N3", 32'h14, 32'h00320233); check("rd.cnt2", instr_count, 32'd4);

        // Backpressure: restart at 0 with id_ready low
        redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
        tick(); redirect_valid = 1'b0;
        tick(); #1; check_head("bp.first", 32'h0, 32'h00002083);
        tick(); tick(); tick(); tick(); #1;
        check_head("bp.hold", 32'h0, 32'h00002083);
        check("bp.addr", {24'b0, imem_addr}, 32'd2);
        check("bp.cnt", instr_count, 32'd4);
        id_ready = 1'b1;
        tick(); #1; check_head("bp.r1", 32'h4, 32'h00402103); check("bp.r1cnt", instr_count, 32'd5);
        tick(); #1; check_head("bp.r2", 32'h8, 32'h000001b3); check("bp.r2cnt", instr_count, 32'd6);
        tick(); #1; check_head("bp.r3", 32'hC, 32'h00000233); check("bp.r3cnt", instr_count, 32'd7);

        // Misaligned redirect to 0x1E
        redirect_valid = 1'b1; redirect_pc = 32'h1E; #1;
        check("mis.validN", {31'b0, if_valid}, 32'd0);
        tick(); redirect_valid = 1'b0; #1;
        check("mis.flag", {31'b0, misalign_err}, 32'd1);
        check("mis.cnt", instr_count, 32'd7);
        tick(); #1; check_head("mis.head", 32'h1C, 32'hfe000ae3);
        check("mis.sticky", {31'b0, misalign_err}, 32'd1);

        // Redirect to the last word, then run past the end of memory
        redirect_valid = 1'b1; redirect_pc = 32'hFC;
        tick(); redirect_valid = 1'b0; #1;
        check("oob.pre", {31'b0, fetch_oob}, 32'd0);
        tick(); #1; check_head("oob.last", 32'hFC, W63);
        check("oob.set", {31'b0, fetch_oob}, 32'd1);
        tick(); #1;
        check("oob.drain", {31'b0, if_valid}, 32'd0);
        check("oob.cnt", instr_count, 32'd8);
        tick(); #1;
        check("oob.stay", {31'b0, if_valid}, 32'd0);
        check("oob.addr", {24'b0, imem_addr}, 32'h40);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick(); redirect_valid = 1'b0; #1;
        check("oob.clr", {31'b0, fetch_oob}, 32'd0);
        tick(); #1; check_head("oob.resume", 32'h0, 32'h00002083);
        check("oob.mis", {31'b0, misalign_err}, 32'd1);

        // Asynchronous reset between edges with the buffer full
        id_ready = 1'b0;
        tick(); tick(); #2;
        check_head("ar.full", 32'h0, 32'h00002083);
        rst = 1'b0; #1;
        check("ar.valid", {31'b0, if_valid}, 32'd0);
        check("ar.pc", if_pc, 32'h0);
        check("ar.cnt", instr_count, 32'd0);
        check("ar.addr", {24'b0, imem_addr}, 32'd0);
        check("ar.mis", {31'b0, misalign_err}, 32'd0);
        tick(); rst = 1'b1; id_ready = 1'b1;
        tick(); #1; check_head("ar.s0", 32'h0, 32'h00002083);
        tick(); #1; check_head("ar.s1", 32'h4, 32'h00402103); check("ar.s1cnt", instr_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch front end and read initiator for the instruction memory.
- Holds the PC and drives the word address to the combinational-read instruction memory.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts branch redirects from execute; counts accepted instructions.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset
MEM_WORDS, 64, instruction memory depth in 32-bit words
ADDR_W, 8, width of the memory word-address port
BUF_DEPTH, 2, fetch buffer entries; power of two, 2 or more

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
imem_addr  output  ADDR_W  word address to instruction memory, equals pc[ADDR_W+1:2]
imem_data  input  32  instruction word from memory, valid the same cycle (combinational read)
id_ready  input  1  decode can accept an instruction this cycle
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  32  instruction at buffer head
if_pc  output  32  byte PC of if_instr
redirect_valid  input  1  branch/jump taken, flush and refetch
redirect_pc  input  32  new byte PC
fetch_oob  output  1  PC is at or beyond MEM_WORDS*4; fetching suspended
misalign_err  output  1  sticky; set when a redirect target has bits [1:0] nonzero
instr_count  output  32  number of completed if_valid&&id_ready transfers

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, buffer count=0, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, instr_count=0. imem_addr follows pc.
- Mid-operation reset clears all state immediately, without waiting for a clock; buffered entries are discarded.
- Fetch/push:
  - A push occurs when count<BUF_DEPTH, fetch_oob=0 and redirect_valid=0.
  - A push writes {pc, imem_data} at the tail and sets pc<=pc+4.
  - Full is judged on the registered count; a same-cycle pop does not free a slot.
- Output/pop:
  - if_valid = (count!=0) && !redirect_valid.
  - if_instr/if_pc come from the head entry, and are 0 when the buffer is empty.
  - Transfer = if_valid && id_ready. It pops the head and increments instr_count, wrapping modulo 2^32.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Latency: the first instruction is valid on the second rising edge after reset deasserts. Memory is sampled at edge 1 and if_valid is high after it.
- Throughput: with id_ready held high, one instruction per cycle with no gaps; count stays at 1.
- Backpressure: with id_ready=0, the buffer fills to BUF_DEPTH, then pc and the outputs hold stable. No instruction is lost or duplicated on release.
- Redirect has priority over push and pop:
  - In the redirect cycle: if_valid is forced low, no transfer, no push, no counter increment.
  - At the clock edge: buffer flushed (count=0), pc <= {redirect_pc[31:2],2'b00}.
  - If redirect_pc[1:0]!=0, misalign_err is set to 1 and cleared only by reset.
  - Penalty: redirect asserted in cycle N, first target instruction valid in cycle N+2.
- Out of range:
  - fetch_oob = (pc >= MEM_WORDS*4), combinational from pc.
  - While it is high, no push occurs; the existing buffer still drains normally.
  - A redirect to an in-range PC resumes fetching.
- Back-to-back redirects: the last one wins; each flushes the buffer.
- Arithmetic: pc+4 wraps modulo 2^32. imem_addr truncates to ADDR_W bits.

Test Plan:
- Memory model holds 0x00002083, 0x00402103, 0x000001b3, 0x00000233, 0x001181b3, 0x00320233, 0x00218463, 0xfe000ae3, 0x00401623 at words 0-8; release reset with id_ready=1 -> if_valid rises after edge 1; pc/instr sequence 0x0/0x00002083, 0x4/0x00402103, 0x8/0x000001b3 on consecutive cycles; instr_count=3 after three transfers.
- Drop id_ready for 5 cycles after the first valid -> count saturates at 2, if_instr held 0x00002083, pc held 0x8; on release -> 0x00402103 then 0x000001b3 back-to-back, no duplicates.
- Assert redirect_valid with redirect_pc=0x10 while streaming -> if_valid=0 in cycles N and N+1, instr_count not incremented; cycle N+2 -> if_pc=0x10, if_instr=0x001181b3.
- Redirect to 0x1E -> misalign_err=1 and stays 1; next valid has if_pc=0x1C, if_instr=0xfe000ae3.
- Redirect to 0xFC with id_ready=1 -> word 0xFC delivered, then pc=0x100, fetch_oob=1, if_valid drops after drain; then redirect to 0x0 -> fetch_oob=0, if_instr=0x00002083.
- Assert rst=0 between clock edges with the buffer full -> if_valid=0, if_pc=0, instr_count=0, imem_addr=0 immediately; after release, normal fetch resumes from 0x0.
